// File: rtl/acc_diff_decoder_pkg.sv
// Shared constants, widths and state encoding for the accumulator
// integrator/differentiator pair. The integrator imports this same package,
// so the step weight and the widths match on both sides.
package acc_diff_decoder_pkg;

  // Per-count weight applied by the integrator, and the largest legal count.
  localparam int STEP_DEFAULT = 25;
  localparam int MAXQ_DEFAULT = 15;

  // Accumulator width, signed difference width, recovered count width.
  localparam int Y_W = 13;
  localparam int D_W = Y_W + 1;
  localparam int Q_W = 4;

  // One quotient bit per divider iteration.
  localparam int DIV_STEPS = Q_W;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  // Decoder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    HOLD = 2'd2
  } dec_state_e;

  // Difference between consecutive accumulator values. A value flagged as the
  // first after a clear is taken as-is. Both operands are zero-extended, so
  // an upstream 13-bit wrap shows up as a negative difference.
  function automatic logic signed [D_W-1:0] acc_delta(
    input logic [Y_W-1:0] y,
    input logic [Y_W-1:0] prev,
    input logic           first
  );
    logic signed [D_W-1:0] y_s;
    logic signed [D_W-1:0] p_s;
    y_s = $signed({1'b0, y});
    p_s = $signed({1'b0, prev});
    return first ? y_s : (y_s - p_s);
  endfunction

  // A difference is only decodable if it lies in [0, limit].
  function automatic logic delta_out_of_range(
    input logic signed [D_W-1:0] delta,
    input logic signed [D_W-1:0] limit
  );
    return (delta < 0) || (delta > limit);
  endfunction

endpackage

// File: rtl/acc_diff_decoder_div.sv
// div_step_seq: sequential restoring divider of a non-negative dividend by
// the constant STEP. One quotient bit per cycle, MSB first, trial divisors
// STEP<<(DIV_STEPS-1) down to STEP<<0. 'done' pulses for one cycle after the
// last iteration; quotient and remainder stay valid until the next start.
module div_step_seq
  import acc_diff_decoder_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [D_W-1:0] dividend,
  output logic [Q_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           done
);

  localparam logic [D_W-1:0]   STEP_W   = D_W'(STEP);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_STEPS - 1);

  logic             busy;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] bit_idx;
  logic [D_W-1:0]   trial;

  // Trial divisor for the quotient bit being resolved this cycle.
  always_comb begin
    bit_idx = LAST_CNT - step_cnt;
    trial   = STEP_W << bit_idx;
  end

  // Load on start, then subtract-if-fits once per cycle for DIV_STEPS cycles.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      step_cnt  <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy      <= 1'b1;
        step_cnt  <= '0;
        quotient  <= '0;
        remainder <= dividend;
      end else if (busy) begin
        if (remainder >= trial) begin
          remainder         <= remainder - trial;
          quotient[bit_idx] <= 1'b1;
        end
        step_cnt <= step_cnt + 1'b1;
        if (step_cnt == LAST_CNT) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/acc_diff_decoder.sv
// acc_diff_decoder: recovers the per-sample count X from a running
// accumulator (y = sum of STEP*X). Each accepted sample is differenced
// against the previous one and divided by STEP; the result is held with a
// valid/ready handshake until the consumer takes it. Non-multiples of STEP,
// negative differences and counts above MAXQ are reported through x_err.
module acc_diff_decoder
  import acc_diff_decoder_pkg::*;
#(
  parameter int STEP = STEP_DEFAULT,
  parameter int MAXQ = MAXQ_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [Y_W-1:0] y_in,
  input  logic           y_start,
  input  logic           y_valid,
  output logic           y_ready,
  output logic [Q_W-1:0] x_out,
  output logic           x_err,
  output logic           x_valid,
  input  logic           x_ready
);

  localparam logic signed [D_W-1:0] LIMIT = D_W'(STEP * MAXQ);

  dec_state_e            state;
  logic [Y_W-1:0]        prev;
  logic                  range_err;
  logic signed [D_W-1:0] delta;
  logic                  accept;
  logic [Q_W-1:0]        div_quotient;
  logic [D_W-1:0]        div_remainder;
  logic                  div_done;
  logic                  result_err;

  // Input is taken only while idle; y_valid in any other state is ignored.
  assign y_ready = (state == IDLE);
  assign accept  = y_valid && y_ready;

  // Difference of this sample against the last accepted one.
  // NOTE: every always_comb output gets a value on every path, otherwise
  // synthesis infers a latch to remember the old value.
  always_comb begin
    delta      = acc_delta(y_in, prev, y_start);
    result_err = range_err || (div_remainder != '0);
  end

  div_step_seq #(
    .STEP (STEP)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (accept),
    .dividend  (delta),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .done      (div_done)
  );

  // Control FSM with registered result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prev      <= '0;
      range_err <= 1'b0;
      x_out     <= '0;
      x_err     <= 1'b0;
      x_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (y_valid) begin
            prev      <= y_in;
            range_err <= delta_out_of_range(delta, LIMIT);
            state     <= DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            x_err   <= result_err;
            x_out   <= result_err ? '0 : div_quotient;
            x_valid <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (x_ready) begin
            x_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_diff_decoder.sv
// Directed bench for acc_diff_decoder: reset state, fixed latency, decode of
// an accumulator sequence, error cases, back-pressure and reset mid-divide.
module tb_acc_diff_decoder;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic [12:0] y_in    = '0;
  logic        y_start = 1'b0;
  logic        y_valid = 1'b0;
  logic        y_ready;
  logic [3:0]  x_out;
  logic        x_err;
  logic        x_valid;
  logic        x_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  acc_diff_decoder dut (
    .clock   (clock),
    .reset   (reset),
    .y_in    (y_in),
    .y_start (y_start),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .x_out   (x_out),
    .x_err   (x_err),
    .x_valid (x_valid),
    .x_ready (x_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) at negedges until the decoder is idle.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (y_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ready"}, 16'(y_ready), 16'd1);
  endtask

  // Present one sample, check latency and result; optionally accept it.
  task automatic run_sample(input string tag, input logic [12:0] y, input logic s,
                            input logic [3:0] ex, input logic ee, input logic take);
    wait_ready(tag);
    y_in    = y;
    y_start = s;
    y_valid = 1'b1;
    x_ready = take;
    @(negedge clock);              // past handshake edge 0
    y_valid = 1'b0;
    y_start = 1'b0;
    check({tag, "_busy"}, 16'(y_ready), 16'd0);
    repeat (4) @(negedge clock);   // past edge 4
    check({tag, "_early"}, 16'(x_valid), 16'd0);
    @(negedge clock);              // past edge 5
    check({tag, "_valid"}, 16'(x_valid), 16'd1);
    check({tag, "_x"}, 16'(x_out), 16'(ex));
    check({tag, "_err"}, 16'(x_err), 16'(ee));
    if (take) begin
      @(negedge clock);            // past edge 6, back in IDLE
      check({tag, "_drop"}, 16'(x_valid), 16'd0);
      check({tag, "_rdy"}, 16'(y_ready), 16'd1);
    end
  endtask

  initial begin
    int seen;

    // Reset state while reset is held.
    #1;
    check("rst_valid", 16'(x_valid), 16'd0);
    check("rst_x", 16'(x_out), 16'd0);
    check("rst_err", 16'(x_err), 16'd0);
    check("rst_ready", 16'(y_ready), 16'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Accumulator 250,375,675,700 -> counts 10,5,12,1.
    run_sample("s250", 13'd250, 1'b1, 4'd10, 1'b0, 1'b1);
    run_sample("s375", 13'd375, 1'b0, 4'd5,  1'b0, 1'b1);
    run_sample("s675", 13'd675, 1'b0, 4'd12, 1'b0, 1'b1);
    run_sample("s700", 13'd700, 1'b0, 4'd1,  1'b0, 1'b1);

    // Non-multiple and negative differences.
    run_sample("r250", 13'd250, 1'b1, 4'd10, 1'b0, 1'b1);
    run_sample("rem",  13'd260, 1'b0, 4'd0,  1'b1, 1'b1);
    run_sample("neg",  13'd200, 1'b0, 4'd0,  1'b1, 1'b1);

    // Range boundary: 400 too large, 375 is the largest legal value.
    run_sample("big",  13'd400, 1'b1, 4'd0,  1'b1, 1'b1);
    run_sample("max",  13'd375, 1'b1, 4'd15, 1'b0, 1'b1);

    // Upstream wrap (375 -> 100) decodes as a negative difference.
    run_sample("wrap", 13'd100, 1'b0, 4'd0,  1'b1, 1'b1);

    // Back-pressure: result held, extra y_valid ignored, prev unchanged.
    run_sample("hold", 13'd150, 1'b1, 4'd6,  1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      y_in    = 13'd999;
      y_valid = 1'b1;
      @(negedge clock);
      check("hold_valid", 16'(x_valid), 16'd1);
      check("hold_x", 16'(x_out), 16'd6);
      check("hold_err", 16'(x_err), 16'd0);
      check("hold_ready", 16'(y_ready), 16'd0);
    end
    y_valid = 1'b0;
    x_ready = 1'b1;
    @(negedge clock);
    check("hold_release", 16'(x_valid), 16'd0);
    run_sample("after_hold", 13'd200, 1'b0, 4'd2, 1'b0, 1'b1);

    // Reset during the divide discards the in-flight result.
    wait_ready("mid");
    y_in    = 13'd300;
    y_start = 1'b1;
    y_valid = 1'b1;
    @(negedge clock);
    y_valid = 1'b0;
    y_start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("mid_valid", 16'(x_valid), 16'd0);
    check("mid_x", 16'(x_out), 16'd0);
    check("mid_err", 16'(x_err), 16'd0);
    check("mid_ready", 16'(y_ready), 16'd1);
    @(negedge clock);
    reset = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (x_valid === 1'b1) seen++;
    end
    check("mid_no_valid", 16'(seen), 16'd0);

    // First sample after reset without y_start differences against 0.
    run_sample("post_rst", 13'd50, 1'b0, 4'd2, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
